// File: rtl/id_ex_lane_pipe_pkg.sv
// id_ex_pkg: shared lane layout for the ID/EX issue-packet stage.
// Holds the control-field struct, the field offsets and the helpers that derive
// the data-dependent offsets and the total lane width from DATA_W/PC_W.
// Lane layout, LSB first:
//   ctrl | rd | rs | rt | shamt | readData1 | readData2 | imm | pc | pcBranch
package id_ex_pkg;

    // Per-lane control bits. Because the struct is packed, memread lands in bit 0.
    typedef struct packed {
        logic [3:0] aluop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       prediction;
        logic       bit26;
        logic       branch;
        logic       alusrc;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
    } lane_ctrl_t;

    localparam int CTRL_W    = $bits(lane_ctrl_t);
    localparam int REG_W     = 5;
    localparam int RD_OFF    = CTRL_W;
    localparam int RS_OFF    = RD_OFF + REG_W;
    localparam int RT_OFF    = RS_OFF + REG_W;
    localparam int SHAMT_OFF = RT_OFF + REG_W;
    localparam int RD1_OFF   = SHAMT_OFF + REG_W;

    function automatic int rd2_off(input int data_w);
        return RD1_OFF + data_w;
    endfunction

    function automatic int imm_off(input int data_w);
        return RD1_OFF + 2 * data_w;
    endfunction

    function automatic int pc_off(input int data_w);
        return RD1_OFF + 3 * data_w;
    endfunction

    function automatic int pcbranch_off(input int data_w, input int pc_w);
        return pc_off(data_w) + pc_w;
    endfunction

    // Total payload bits carried by one lane.
    function automatic int lane_w(input int data_w, input int pc_w);
        return pc_off(data_w) + 2 * pc_w;
    endfunction

endpackage

// File: rtl/id_ex_lane_pipe_lane_reg.sv
// id_ex_lane_reg: a single lane's valid bit and payload register.
// Flush has priority over load, and load has priority over hold. When a bubble
// lane is loaded, its payload is stored as zero, so a lane that is not valid
// always reads back all-zero.
module id_ex_lane_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         load,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         valid_nxt,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    // Next-state selection: flush > load > hold.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load) begin
            valid_d = in_valid;
            data_d  = in_valid ? in_data : '0;
        end
    end

    // Lane state register; an asynchronous reset clears the lane.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: use non-blocking assignments so that every flop samples pre-edge values.
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_nxt = valid_d;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/id_ex_lane_pipe.sv
// id_ex_lane_pipe: ID/EX stage that carries a LANES-wide issue packet and uses
// a valid/ready handshake. Flush is applied per lane.
// The optional macro ID_EX_SKID_EN adds one skid packet, so that in_ready comes
// directly from a flop. When the macro is not defined, in_ready is combinational.
module id_ex_lane_pipe
    import id_ex_pkg::*;
#(
    parameter  int LANES  = 2,
    parameter  int DATA_W = 32,
    parameter  int PC_W   = 8,
    localparam int LANE_W = lane_w(DATA_W, PC_W)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic                    in_ready,
    input  logic [LANES-1:0]        flush,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*LANE_W-1:0] out_data,
    input  logic                    out_ready
);

    logic                    main_full;
    logic                    main_load;
    logic [LANES-1:0]        main_src_valid;
    logic [LANES*LANE_W-1:0] main_src_data;
    logic [LANES-1:0]        main_valid_nxt;

    // A packet that has been flushed to all-bubble counts as empty, so it never blocks a load.
    assign main_full = |out_valid;
    assign main_load = ~main_full | out_ready;

`ifdef ID_EX_SKID_EN
    logic [LANES-1:0]        skid_valid;
    logic [LANES-1:0]        skid_valid_nxt;
    logic [LANES*LANE_W-1:0] skid_data;
    logic [LANES-1:0]        skid_src_valid;
    logic [LANES*LANE_W-1:0] skid_src_data;
    logic                    skid_full;
    logic                    skid_load;
    logic                    in_ready_q, in_ready_d;

    assign skid_full = |skid_valid;

    // Source selection: the skid always drains into main before new input is taken.
    // The skid captures input only while it accepts (skid empty) and main is blocked.
    always_comb begin
        main_src_valid = in_valid;
        main_src_data  = in_data;
        skid_src_valid = in_valid;
        skid_src_data  = in_data;
        skid_load      = ~main_load;
        if (skid_full) begin
            main_src_valid = skid_valid;
            main_src_data  = skid_data;
            skid_src_valid = '0;
            skid_src_data  = '0;
            skid_load      = main_load;
        end
        in_ready_d = ~|skid_valid_nxt;
    end

    // Registered upstream ready, which is high exactly when the skid is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;

    for (genvar i = 0; i < LANES; i++) begin : g_skid
        id_ex_lane_reg #(.W(LANE_W)) u_skid_lane (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush[i]),
            .load      (skid_load),
            .in_valid  (skid_src_valid[i]),
            .in_data   (skid_src_data[i*LANE_W +: LANE_W]),
            .valid_nxt (skid_valid_nxt[i]),
            .out_valid (skid_valid[i]),
            .out_data  (skid_data[i*LANE_W +: LANE_W])
        );
    end
`else
    // Without a skid, main always loads directly from decode.
    always_comb begin
        main_src_valid = in_valid;
        main_src_data  = in_data;
    end

    assign in_ready = main_load;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_main
        id_ex_lane_reg #(.W(LANE_W)) u_main_lane (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush[i]),
            .load      (main_load),
            .in_valid  (main_src_valid[i]),
            .in_data   (main_src_data[i*LANE_W +: LANE_W]),
            .valid_nxt (main_valid_nxt[i]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*LANE_W +: LANE_W])
        );
    end

endmodule

// File: tb/tb_id_ex_lane_pipe.sv
// tb_id_ex_lane_pipe: directed-plus-random bench for id_ex_lane_pipe.
// A queue of expected packets (head = execute side) is updated on every edge
// from the driven stimulus, and the DUT outputs are compared against the head.
module tb_id_ex_lane_pipe;
    import id_ex_pkg::*;

    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int PW_PC = 8;
    localparam int LW    = lane_w(DW, PW_PC);
    localparam int PW    = LANES * LW;
    localparam int IMM_O = imm_off(DW);
    localparam int PC_O  = pc_off(DW);
    localparam int PCB_O = pcbranch_off(DW, PW_PC);

    logic              clk;
    logic              reset;
    logic [LANES-1:0]  in_valid;
    logic [PW-1:0]     in_data;
    logic              in_ready;
    logic [LANES-1:0]  flush;
    logic [LANES-1:0]  out_valid;
    logic [PW-1:0]     out_data;
    logic              out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [LANES-1:0] v;
        logic [PW-1:0]    d;
    } pkt_t;

    pkt_t sb[$];

    id_ex_lane_pipe #(.LANES(LANES), .DATA_W(DW), .PC_W(PW_PC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk_lane(input logic [7:0] pc, input logic [4:0] rd,
                                             input logic regwrite, input logic [31:0] rd1);
        logic [LW-1:0] l;
        lane_ctrl_t    c;
        l = '0;
        c = '0;
        c.regwrite = regwrite;
        c.aluop    = 4'h2;
        c.memread  = pc[2];
        l[CTRL_W-1:0]       = c;
        l[RD_OFF +: 5]      = rd;
        l[RS_OFF +: 5]      = rd + 5'd1;
        l[RD1_OFF +: 32]    = rd1;
        l[IMM_O +: 32]      = rd1 ^ 32'h5a5a_0f0f;
        l[PC_O +: 8]        = pc;
        l[PCB_O +: 8]       = pc + 8'd4;
        return l;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [7:0] pc0, input logic [7:0] pc1,
                         input logic [1:0] fl, input logic ordy);
        in_valid  = v;
        in_data   = {mk_lane(pc1, 5'd7, 1'b1, 32'h1111_0000 | 32'(pc1)),
                     mk_lane(pc0, 5'd3, 1'b0, 32'hbeef_0000 | 32'(pc0))};
        flush     = fl;
        out_ready = ordy;
    endtask

    // This function gives the ready value expected from the current model state and the current out_ready.
    function automatic logic exp_in_ready();
`ifdef ID_EX_SKID_EN
        return sb.size() < 2;
`else
        return !(sb.size() > 0 && (|sb[0].v)) || out_ready;
`endif
    endfunction

    // This task updates the model for one edge, using the inputs that were held across that edge.
    task automatic model_update(input logic rdy);
        pkt_t p;
        if (sb.size() > 0)
            if (!(|sb[0].v) || out_ready) void'(sb.pop_front());
        if (rdy) begin
            p.v = in_valid;
            p.d = in_data;
            for (int i = 0; i < LANES; i++)
                if (!in_valid[i]) p.d[i*LW +: LW] = '0;
            sb.push_back(p);
        end
        for (int k = 0; k < sb.size(); k++) begin
            p = sb[k];
            for (int i = 0; i < LANES; i++)
                if (flush[i]) begin
                    p.v[i] = 1'b0;
                    p.d[i*LW +: LW] = '0;
                end
            sb[k] = p;
        end
        for (int k = sb.size() - 1; k >= 1; k--)
            if (!(|sb[k].v)) sb.delete(k);
    endtask

    task automatic step(input string tag);
        logic             rdy;
        logic [LANES-1:0] ev;
        logic [PW-1:0]    ed;
        #1;
        rdy = exp_in_ready();
        check({tag, ".in_ready"}, PW'(in_ready), PW'(rdy));
        @(posedge clk);
        model_update(rdy);
        @(negedge clk);
        ev = '0;
        ed = '0;
        if (sb.size() > 0) begin
            ev = sb[0].v;
            ed = sb[0].d;
        end
        check({tag, ".out_valid"}, PW'(out_valid), PW'(ev));
        check({tag, ".out_data"}, out_data, ed);
    endtask

    initial begin
        // Hold reset low while driving a live packet; the outputs must stay clear.
        reset = 1'b0;
        drive(2'b11, 8'h04, 8'h84, 2'b00, 1'b1);
        @(negedge clk);
        check("rst.out_valid", PW'(out_valid), PW'(2'b00));
        check("rst.out_data", out_data, '0);
        check("rst.in_ready", PW'(in_ready), PW'(1'b1));
        reset = 1'b1;
        step("rst_release_load");

        // Streaming: packets arrive back-to-back with no bubbles.
        drive(2'b11, 8'h10, 8'h90, 2'b00, 1'b1); step("stream10");
        drive(2'b11, 8'h14, 8'h94, 2'b00, 1'b1); step("stream14");
        drive(2'b11, 8'h18, 8'h98, 2'b00, 1'b1); step("stream18");

        // Stall for three cycles while decode keeps offering packets.
        drive(2'b11, 8'h1c, 8'h9c, 2'b00, 1'b0); step("stall0");
        drive(2'b11, 8'h20, 8'ha0, 2'b00, 1'b0); step("stall1");
        drive(2'b11, 8'h24, 8'ha4, 2'b00, 1'b0); step("stall2");
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); step("drain0");
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); step("drain1");
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); step("drain2");

        // Flush a held lane1 (regwrite=1, rd=7); lane0 must be unaffected.
        drive(2'b11, 8'h30, 8'hb0, 2'b00, 1'b0); step("flush_fill");
        drive(2'b00, 8'h00, 8'h00, 2'b10, 1'b0); step("flush_held");
        check("flush_held.lane1", PW'(out_data[LW +: LW]), '0);

        // Flush lane0 on a loading edge.
        drive(2'b11, 8'h40, 8'hc0, 2'b01, 1'b1); step("flush_load");
        check("flush_load.valid", PW'(out_valid), PW'(2'b10));
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); step("idle0");

        // Reset in the middle of a stall, with decode still pushing data.
        drive(2'b11, 8'h50, 8'hd0, 2'b00, 1'b0); step("mrst_fill0");
        drive(2'b11, 8'h54, 8'hd4, 2'b00, 1'b0); step("mrst_fill1");
        drive(2'b11, 8'h58, 8'hd8, 2'b00, 1'b0); step("mrst_fill2");
        #2 reset = 1'b0;
        #1;
        sb.delete();
        check("mrst.out_valid", PW'(out_valid), PW'(2'b00));
        check("mrst.out_data", out_data, '0);
        check("mrst.in_ready", PW'(in_ready), PW'(1'b1));
        @(negedge clk);
        reset = 1'b1;
        drive(2'b01, 8'h60, 8'he0, 2'b00, 1'b1); step("mrst_after");

        // Random traffic, including bubbles, stalls and occasional flushes.
        for (int n = 0; n < 60; n++) begin
            drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  1'($urandom_range(0, 1)));
            step("rnd");
        end

        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); step("final0");
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1); step("final1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
